run_controller: RTL and testbench

Run-control sequencer for the single-cycle ARM core. It holds the core idle after reset and launches it on a synchronized `start` rising edge with a one-cycle core reset pulse. It then gates the core clock enable while counting executed cycles, and stops the core when the program writes its completion word to a sentinel data address, or when a cycle budget expires. It sits between the board-level `start` input and the core inside `top`, snooping the core's data-memory write bus.

---
 rtl/run_ctrl_pkg.sv | 14 +
 rtl/run_controller_sync_rise.sv | 27 ++
 rtl/run_controller.sv | 117 +++++++++++
 tb/tb_run_controller.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/run_ctrl_pkg.sv
// Shared types and defaults for the ARM core run-control sequencer.
package run_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    RUN   = 3'd2,
    DONE  = 3'd3,
    FAULT = 3'd4
  } run_state_t;

  localparam logic [31:0] DEFAULT_DONE_ADDR = 32'd200;

endpackage

// File: rtl/run_controller_sync_rise.sv
// Two-flop synchronizer plus history flop; emits one pulse per low-to-high edge.
module sync_rise (
  input  logic clk,
  input  logic rst,
  input  logic i_async,
  output logic o_rise_c
);

  logic r_s1;
  logic r_s2;
  logic r_s3;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
      r_s3 <= 1'b0;
    end else begin
      r_s1 <= i_async;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  assign o_rise_c = r_s2 & ~r_s3;

endmodule

// File: rtl/run_controller.sv
// Run-control sequencer: launches the core on start, counts RUN cycles, and
// stops on a completion store to DONE_ADDR or when the cycle budget expires.
module run_controller
  import run_ctrl_pkg::*;
#(
  parameter logic [31:0] DONE_ADDR = DEFAULT_DONE_ADDR,
  parameter int unsigned CNT_W     = 32,
  parameter int unsigned TIMEOUT   = 100000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             MemWrite,
  input  logic [31:0]      DataAdr,
  input  logic [31:0]      WriteData,
  output logic             core_en,
  output logic             core_reset,
  output logic             busy,
  output logic             done,
  output logic             timeout,
  output logic [31:0]      result,
  output logic [CNT_W-1:0] cycles
);

  localparam logic [CNT_W-1:0] CYC_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CYC_MAX  = '1;

  logic             w_start_rise;
  logic             w_complete;
  run_state_t       r_state;
  logic             r_core_en;
  logic             r_clear;
  logic             r_busy;
  logic             r_done;
  logic             r_timeout;
  logic [31:0]      r_result;
  logic [CNT_W-1:0] r_cycles;

  sync_rise u_sync_rise (
    .clk      (clk),
    .rst      (reset),
    .i_async  (start),
    .o_rise_c (w_start_rise)
  );

  assign w_complete = MemWrite && (DataAdr == DONE_ADDR);

  // Outputs are registered alongside the state they decode.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= IDLE;
      r_core_en <= 1'b0;
      r_clear   <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_timeout <= 1'b0;
      r_result  <= '0;
      r_cycles  <= '0;
    end else begin
      case (r_state)
        IDLE, DONE, FAULT: begin
          if (w_start_rise) begin
            r_state   <= CLEAR;
            r_clear   <= 1'b1;
            r_busy    <= 1'b1;
            r_done    <= 1'b0;
            r_timeout <= 1'b0;
            r_core_en <= 1'b0;
            r_result  <= '0;
            r_cycles  <= '0;
          end
        end
        CLEAR: begin
          r_state   <= RUN;
          r_clear   <= 1'b0;
          r_core_en <= 1'b1;
        end
        RUN: begin
          if (r_cycles != CYC_MAX) begin
            r_cycles <= r_cycles + CNT_W'(1);
          end
          // Completion takes priority over an expiring budget.
          if (w_complete) begin
            r_state   <= DONE;
            r_result  <= WriteData;
            r_core_en <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b1;
          end else if (r_cycles == CYC_LAST) begin
            r_state   <= FAULT;
            r_core_en <= 1'b0;
            r_busy    <= 1'b0;
            r_timeout <= 1'b1;
          end
        end
        default: begin
          r_state   <= IDLE;
          r_core_en <= 1'b0;
          r_clear   <= 1'b0;
          r_busy    <= 1'b0;
          r_done    <= 1'b0;
          r_timeout <= 1'b0;
        end
      endcase
    end
  end

  // Core reset follows the controller reset asynchronously.
  assign core_reset = reset | r_clear;
  assign core_en    = r_core_en;
  assign busy       = r_busy;
  assign done       = r_done;
  assign timeout    = r_timeout;
  assign result     = r_result;
  assign cycles     = r_cycles;

endmodule

// File: tb/tb_run_controller.sv
// Scoreboard bench for run_controller: a core model replays per-cycle store
// programs, a reference model predicts each run's outcome, a monitor checks it.
module tb_run_controller;

  localparam int unsigned TMO   = 16;
  localparam logic [31:0] DADDR = 32'd200;
  localparam int          PLEN  = 40;

  typedef struct packed {
    logic        is_done;
    logic [31:0] res;
    logic [31:0] cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        MemWrite = 1'b0;
  logic [31:0] DataAdr = '0;
  logic [31:0] WriteData = '0;
  logic        core_en;
  logic        core_reset;
  logic        busy;
  logic        done;
  logic        timeout;
  logic [31:0] result;
  logic [31:0] cycles;

  run_controller #(.DONE_ADDR(DADDR), .CNT_W(32), .TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset), .start(start), .MemWrite(MemWrite),
    .DataAdr(DataAdr), .WriteData(WriteData), .core_en(core_en),
    .core_reset(core_reset), .busy(busy), .done(done), .timeout(timeout),
    .result(result), .cycles(cycles)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int n_fin   = 0;
  int k_en    = 0;
  int cr_cnt  = 0;
  logic prev_fin = 1'b0;
  logic prev_en  = 1'b0;

  logic        prog_we  [1:PLEN];
  logic [31:0] prog_adr [1:PLEN];
  logic [31:0] prog_dat [1:PLEN];
  exp_t        exp_q [$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Outcome of a run from its store program: first sentinel store within budget wins.
  function automatic exp_t model();
    exp_t e;
    e.is_done = 1'b0;
    e.res     = '0;
    e.cyc     = TMO;
    for (int k = 1; k <= int'(TMO); k++) begin
      if (prog_we[k] && prog_adr[k] == DADDR) begin
        e.is_done = 1'b1;
        e.res     = prog_dat[k];
        e.cyc     = 32'(k);
        return e;
      end
    end
    return e;
  endfunction

  task automatic clear_prog();
    for (int k = 1; k <= PLEN; k++) begin
      prog_we[k]  = 1'b0;
      prog_adr[k] = '0;
      prog_dat[k] = '0;
    end
  endtask

  task automatic set_store(input int k, input logic [31:0] a, input logic [31:0] d);
    prog_we[k]  = 1'b1;
    prog_adr[k] = a;
    prog_dat[k] = d;
  endtask

  // Core model: drives the store programmed for its k-th enabled cycle.
  always @(negedge clk) begin
    if (core_reset) k_en = 0;
    else if (core_en) k_en++;
    if (!core_reset && core_en && k_en >= 1 && k_en <= PLEN) begin
      MemWrite  = prog_we[k_en];
      DataAdr   = prog_adr[k_en];
      WriteData = prog_dat[k_en];
    end else begin
      MemWrite  = 1'b0;
      DataAdr   = '0;
      WriteData = '0;
    end
  end

  // Monitor: on every run end, pop the prediction and compare.
  always @(negedge clk) begin
    logic fin;
    exp_t e;
    fin = done | timeout;
    if (reset) cr_cnt = 0;
    else if (core_reset) cr_cnt++;
    if (!reset && fin && !prev_fin) begin
      n_fin++;
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_end: got done=%0b timeout=%0b expected no run", done, timeout);
      end else begin
        e = exp_q.pop_front();
        chk("done", 32'(done), 32'(e.is_done));
        chk("timeout", 32'(timeout), 32'(!e.is_done));
        chk("result", result, e.res);
        chk("cycles", cycles, e.cyc);
        chk("en_falls_with_end", {30'd0, prev_en, core_en}, 32'd2);
        chk("core_reset_pulse_len", 32'(cr_cnt), 32'd1);
        chk("busy_after_end", 32'(busy), 32'd0);
      end
      cr_cnt = 0;
    end
    prev_fin = fin;
    prev_en  = core_en;
  end

  task automatic wait_fin(input int base, input string nm);
    int i;
    for (i = 0; i < 200 && n_fin == base; i++) @(negedge clk);
    chk(nm, 32'(n_fin - base), 32'd1);
  endtask

  // Launch one run; optionally leave start high afterwards.
  task automatic go(input int hold, input bit keep);
    int base;
    base = n_fin;
    exp_q.push_back(model());
    start = 1'b1;
    repeat (hold) @(negedge clk);
    wait_fin(base, "run_finished");
    if (!keep) begin
      start = 1'b0;
      repeat (3) @(negedge clk);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no end expected finish by 200us");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad;
    int base;
    int i;
    clear_prog();

    // Reset and idle
    #10;
    chk("rst_core_reset", 32'(core_reset), 32'd1);
    chk("rst_core_en", 32'(core_en), 32'd0);
    chk("rst_flags", {29'd0, busy, done, timeout}, 32'd0);
    chk("rst_cycles", cycles, 32'd0);
    chk("rst_result", result, 32'd0);
    #12 reset = 1'b0;
    bad = 0;
    repeat (50) begin
      @(negedge clk);
      if (core_en | core_reset | busy | done | timeout) bad++;
    end
    chk("idle_quiet_cycles", 32'(bad), 32'd0);
    chk("idle_cycles", cycles, 32'd0);

    // Normal run: 5 stored to 200 on the 12th enabled cycle
    clear_prog();
    set_store(12, DADDR, 32'd5);
    go(4, 1'b0);

    // Non-sentinel stores are ignored; a later second sentinel store is never reached
    clear_prog();
    set_store(3, 32'd196, 32'h1111);
    set_store(5, 32'd204, 32'h2222);
    set_store(8, DADDR, 32'hABCD_1234);
    set_store(9, DADDR, 32'h9999);
    go(3, 1'b0);

    // Timeout, then completion on the final budgeted cycle
    clear_prog();
    go(3, 1'b0);
    clear_prog();
    set_store(TMO, DADDR, 32'h77);
    go(3, 1'b0);

    // Held start: one run only, then restart after a low period
    clear_prog();
    set_store(4, DADDR, 32'h44);
    go(3, 1'b1);
    base = n_fin;
    bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (busy) bad++;
    end
    chk("held_start_no_rerun", 32'(bad + n_fin - base), 32'd0);
    chk("held_start_done_holds", 32'(done), 32'd1);
    start = 1'b0;
    repeat (3) @(negedge clk);
    clear_prog();
    set_store(6, DADDR, 32'h66);
    base = n_fin;
    exp_q.push_back(model());
    start = 1'b1;
    for (i = 0; i < 20 && !busy; i++) @(negedge clk);
    chk("restart_clear_core_reset", 32'(core_reset), 32'd1);
    chk("restart_clear_cycles", cycles, 32'd0);
    chk("restart_clear_en", 32'(core_en), 32'd0);
    wait_fin(base, "restart_finished");
    start = 1'b0;
    repeat (3) @(negedge clk);

    // Reset mid-run at RUN cycle 7, start held through
    clear_prog();
    set_store(12, DADDR, 32'hC0DE);
    start = 1'b1;
    for (i = 0; i < 40 && !(busy && cycles == 32'd6); i++) @(negedge clk);
    chk("midrun_reached", cycles, 32'd6);
    reset = 1'b1;
    #1;
    chk("midrun_core_en", 32'(core_en), 32'd0);
    chk("midrun_core_reset", 32'(core_reset), 32'd1);
    chk("midrun_flags", {29'd0, busy, done, timeout}, 32'd0);
    chk("midrun_cycles", cycles, 32'd0);
    chk("midrun_result", result, 32'd0);
    repeat (2) @(negedge clk);
    base = n_fin;
    exp_q.push_back(model());
    reset = 1'b0;
    wait_fin(base, "post_reset_run");
    base = n_fin;
    bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (busy) bad++;
    end
    chk("post_reset_single_run", 32'(bad + n_fin - base), 32'd0);
    start = 1'b0;
    repeat (3) @(negedge clk);

    // Randomized store programs
    for (int r = 0; r < 20; r++) begin
      int ns;
      logic [31:0] a;
      clear_prog();
      ns = int'($urandom_range(0, 4));
      for (int s = 0; s < ns; s++) begin
        case ($urandom_range(0, 3))
          0: a = 32'd196;
          1: a = DADDR;
          2: a = 32'd204;
          default: a = $urandom;
        endcase
        set_store(int'($urandom_range(1, 20)), a, $urandom);
      end
      go(int'($urandom_range(2, 5)), 1'b0);
    end

    repeat (5) @(negedge clk);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
